branch_ckpt_ctrl: RTL and testbench
===================================

Name: branch_ckpt_ctrl

Overview:
Checkpoint controller for the physical-register free list. Takes a free-list snapshot for every dispatched branch and keeps the snapshots in an age-ordered circular buffer. Releases a checkpoint when its branch resolves correctly. On a mispredict it drives the restore snapshot and restore pulse into the free list (`free_list_restore` / `restore_flag`) and squashes that checkpoint and every younger one.

Parameters:
NUM_CKPT, 8, number of checkpoint slots; must be a power of 2 and ≥2
FL_WIDTH, `PHYS_REG_SZ_R10K, width of a free-list snapshot
ID_BITS, $clog2(NUM_CKPT), width of a checkpoint id

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
alloc_req  in  1  dispatch has a branch this cycle
alloc_snapshot  in  FL_WIDTH  free list as seen by that branch (post-dispatch of older instrs in the bundle)
alloc_gnt  out  1  checkpoint granted this cycle (combinational)
alloc_id  out  ID_BITS  id given to the branch (= tail; valid when alloc_gnt)
ckpt_full  out  1  all NUM_CKPT slots valid (registered state)
resolve_valid  in  1  a branch resolves this cycle
resolve_id  in  ID_BITS  checkpoint id of the resolving branch
resolve_mispredict  in  1  1 = mispredicted, 0 = correct
free_list_restore  out  FL_WIDTH  snapshot to restore; 0 when restore_flag=0
restore_flag  out  1  one-cycle restore pulse to the free list
squash_mask  out  NUM_CKPT  one-cycle pulse: ids invalidated by the mispredict (includes resolve_id)
num_valid  out  ID_BITS+1  count of live checkpoints

Behaviour:
- State:
  - snap[NUM_CKPT], valid[NUM_CKPT], done[NUM_CKPT];
  - head (oldest), tail (next alloc), ID_BITS wide; wrap modulo NUM_CKPT;
  - count, ID_BITS+1 wide.
- Reset: all valid/done=0, head=tail=0, count=0, restore_flag=0, free_list_restore=0, squash_mask=0, ckpt_full=0, num_valid=0. Reset mid-operation discards every checkpoint; no restore pulse is issued.
- Allocation:
  - alloc_gnt = alloc_req & ~ckpt_full & ~(resolve_valid & resolve_mispredict & valid[resolve_id]).
  - On a grant, at the clock edge: snap[tail]<=alloc_snapshot, valid[tail]<=1, done[tail]<=0, tail<=tail+1.
  - alloc_req while full: no grant and no state change; dispatch stalls.
- Valid resolve: resolve_valid with valid[resolve_id]=1.
  - A resolve on an invalid id is ignored.
- Correct resolve: done[resolve_id]<=1.
- Retirement of correct checkpoints:
  - Each cycle, if valid[head] & done[head], clear valid[head] and head<=head+1.
  - At most one release per cycle, in order. This is separate from any new resolve in the same cycle.
- Mispredict resolve on id k:
  - Next edge: free_list_restore<=snap[k], restore_flag<=1. Latency 1 cycle from resolve to restore pulse.
  - squash_mask<=bits k..tail-1 (circular), all with valid=1.
  - Clear valid/done for those bits; tail<=k.
  - Next cycle, restore_flag and squash_mask return to 0 unless another mispredict occurs.
- Age rule: id j is younger than k iff ((j-head) mod NUM_CKPT) > ((k-head) mod NUM_CKPT).
- Simultaneous events:
  - Mispredict + head release of an older entry in the same cycle: both are applied.
  - If the mispredict squashes the head entry, the head release is suppressed and head is unchanged.
  - Mispredict + alloc: the alloc is dropped (see alloc_gnt).
  - Release + alloc while full: the alloc is still refused, because ckpt_full is registered.
- count: next = count + alloc_gnt − release − popcount(squash set). num_valid=count; ckpt_full=(count==NUM_CKPT).
- Wrap: tail==head means empty when count==0 and full when count==NUM_CKPT.

Optional Feature:
BRANCH_CKPT_PERF_EN:
- Defined: adds outputs perf_mispredicts[31:0] and perf_full_stalls[31:0].
  - perf_mispredicts increments on each valid mispredict.
  - perf_full_stalls increments each cycle with alloc_req & ckpt_full.
  - Both saturate at 2^32−1 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. NUM_CKPT=4, reset → alloc 4 branches with snapshots 0x1,0x2,0x4,0x8 → alloc_id 0,1,2,3; ckpt_full=1; 5th alloc_req gives alloc_gnt=0.
2. From state 1, resolve id1 mispredict → next cycle restore_flag=1, free_list_restore=0x2, squash_mask=4'b1110, num_valid=1, tail=1; following cycle restore_flag=0.
3. Correct resolve id1 then id0 (two cycles) → no release until id0 done; head advances 0→1→2 on consecutive cycles; num_valid drops by 1 per cycle.
4. Wrap: head=3, tail=1 (ids 3,0 valid); mispredict id0 → squash_mask=4'b0001, tail=0, id3 remains valid.
5. Same cycle: alloc_req=1 and mispredict on valid id2 → alloc_gnt=0, tail=2, restore pulse carries snap[2].
6. Resolve on invalid id, and reset asserted mid-restore cycle → no state change for the invalid id; after reset all outputs are 0 and num_valid=0.

Source files
------------

// File: rtl/branch_ckpt_ctrl.sv
// branch_ckpt_ctrl: free-list checkpoint buffer for in-flight branches.
// Each dispatched branch takes a snapshot of the free list into an
// age-ordered circular buffer (head = oldest, tail = next slot). Correctly
// resolved checkpoints retire in order from the head; a mispredict restores
// the free list from its snapshot and squashes it and every younger slot.
// Optional build macro: BRANCH_CKPT_PERF_EN adds saturating counters for
// mispredicts and full-buffer dispatch stalls.

`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module branch_ckpt_ctrl #(
    parameter int NUM_CKPT = 8,
    parameter int FL_WIDTH = `PHYS_REG_SZ_R10K,
    parameter int ID_BITS  = $clog2(NUM_CKPT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_req,
    input  logic [FL_WIDTH-1:0] alloc_snapshot,
    output logic                alloc_gnt,
    output logic [ID_BITS-1:0]  alloc_id,
    output logic                ckpt_full,
    input  logic                resolve_valid,
    input  logic [ID_BITS-1:0]  resolve_id,
    input  logic                resolve_mispredict,
    output logic [FL_WIDTH-1:0] free_list_restore,
    output logic                restore_flag,
    output logic [NUM_CKPT-1:0] squash_mask,
`ifdef BRANCH_CKPT_PERF_EN
    output logic [31:0]         perf_mispredicts,
    output logic [31:0]         perf_full_stalls,
`endif
    output logic [ID_BITS:0]    num_valid
);

    localparam logic [ID_BITS:0]   FULL_CNT = (ID_BITS+1)'(NUM_CKPT);
    localparam logic [ID_BITS-1:0] ID_ONE   = {{(ID_BITS-1){1'b0}}, 1'b1};

    // Number of set bits in a slot vector.
    function automatic logic [ID_BITS:0] popcount(input logic [NUM_CKPT-1:0] v);
        logic [ID_BITS:0] c;
        c = {(ID_BITS+1){1'b0}};
        for (int i = 0; i < NUM_CKPT; i++) begin
            c = c + {{ID_BITS{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Slots at the same age as k or younger (distance from head >= that of k),
    // restricted to live slots; this is exactly k..tail-1 when k is live.
    function automatic logic [NUM_CKPT-1:0] younger_or_same(
        input logic [ID_BITS-1:0]  k,
        input logic [ID_BITS-1:0]  head,
        input logic [NUM_CKPT-1:0] live
    );
        logic [NUM_CKPT-1:0] m;
        logic [ID_BITS-1:0]  rel_k;
        logic [ID_BITS-1:0]  rel_i;
        rel_k = k - head;
        m     = {NUM_CKPT{1'b0}};
        for (int i = 0; i < NUM_CKPT; i++) begin
            rel_i = ID_BITS'(i) - head;
            m[i]  = live[i] & (rel_i >= rel_k);
        end
        return m;
    endfunction

    logic [FL_WIDTH-1:0] snap_r [NUM_CKPT];
    logic [NUM_CKPT-1:0] valid_r;
    logic [NUM_CKPT-1:0] done_r;
    logic [ID_BITS-1:0]  head_r;
    logic [ID_BITS-1:0]  tail_r;
    logic [ID_BITS:0]    count_r;

    logic                hit_s;
    logic                mispred_s;
    logic                correct_s;
    logic                release_s;
    logic [NUM_CKPT-1:0] squash_s;
    logic [NUM_CKPT-1:0] valid_next_s;
    logic [NUM_CKPT-1:0] done_next_s;
    logic [ID_BITS-1:0]  head_next_s;
    logic [ID_BITS-1:0]  tail_next_s;
    logic [ID_BITS:0]    count_next_s;

    assign alloc_id  = tail_r;
    assign num_valid = count_r;

    // Resolve classification, squash set, head release and grant decision.
    always_comb begin
        hit_s     = resolve_valid & valid_r[resolve_id];
        mispred_s = hit_s & resolve_mispredict;
        correct_s = hit_s & ~resolve_mispredict;
        squash_s  = mispred_s ? younger_or_same(resolve_id, head_r, valid_r)
                              : {NUM_CKPT{1'b0}};
        // A squashed head cannot also retire this cycle.
        release_s = valid_r[head_r] & done_r[head_r] & ~squash_s[head_r];
        // A mispredict in the same cycle drops the allocation.
        alloc_gnt = alloc_req & ~ckpt_full & ~mispred_s;
    end

    // Next-state for slot flags, pointers and live count.
    always_comb begin
        valid_next_s = valid_r;
        done_next_s  = done_r;
        for (int i = 0; i < NUM_CKPT; i++) begin
            valid_next_s[i] = (valid_r[i] | (alloc_gnt & (tail_r == ID_BITS'(i))))
                              & ~(release_s & (head_r == ID_BITS'(i)))
                              & ~squash_s[i];
            done_next_s[i]  = (done_r[i] | (correct_s & (resolve_id == ID_BITS'(i))))
                              & ~(alloc_gnt & (tail_r == ID_BITS'(i)))
                              & ~(release_s & (head_r == ID_BITS'(i)))
                              & ~squash_s[i];
        end
        head_next_s  = release_s ? (head_r + ID_ONE) : head_r;
        tail_next_s  = mispred_s ? resolve_id
                                 : (alloc_gnt ? (tail_r + ID_ONE) : tail_r);
        count_next_s = count_r
                     + {{ID_BITS{1'b0}}, alloc_gnt}
                     - {{ID_BITS{1'b0}}, release_s}
                     - popcount(squash_s);
    end

    // Checkpoint storage, pointers, count and registered restore outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                snap_r[i] <= {FL_WIDTH{1'b0}};
            end
            valid_r           <= {NUM_CKPT{1'b0}};
            done_r            <= {NUM_CKPT{1'b0}};
            head_r            <= {ID_BITS{1'b0}};
            tail_r            <= {ID_BITS{1'b0}};
            count_r           <= {(ID_BITS+1){1'b0}};
            ckpt_full         <= 1'b0;
            restore_flag      <= 1'b0;
            free_list_restore <= {FL_WIDTH{1'b0}};
            squash_mask       <= {NUM_CKPT{1'b0}};
        end else begin
            if (alloc_gnt) begin
                snap_r[tail_r] <= alloc_snapshot;
            end
            valid_r           <= valid_next_s;
            done_r            <= done_next_s;
            head_r            <= head_next_s;
            tail_r            <= tail_next_s;
            count_r           <= count_next_s;
            ckpt_full         <= (count_next_s == FULL_CNT);
            restore_flag      <= mispred_s;
            free_list_restore <= mispred_s ? snap_r[resolve_id] : {FL_WIDTH{1'b0}};
            squash_mask       <= squash_s;
        end
    end

`ifdef BRANCH_CKPT_PERF_EN
    // Saturating event counters for mispredicts and full-buffer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_mispredicts <= 32'd0;
            perf_full_stalls <= 32'd0;
        end else begin
            if (mispred_s && (perf_mispredicts != 32'hFFFF_FFFF)) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
            if (alloc_req && ckpt_full && (perf_full_stalls != 32'hFFFF_FFFF)) begin
                perf_full_stalls <= perf_full_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed bench for branch_ckpt_ctrl (NUM_CKPT=4, 16-bit snapshots).
// Expected registered outputs are queued when a step is driven and popped
// and compared one edge later; grant/id are compared before the edge.

module tb_branch_ckpt_ctrl;

    localparam int NC = 4;
    localparam int FW = 16;
    localparam int IB = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          alloc_req;
    logic [FW-1:0] alloc_snapshot;
    logic          alloc_gnt;
    logic [IB-1:0] alloc_id;
    logic          ckpt_full;
    logic          resolve_valid;
    logic [IB-1:0] resolve_id;
    logic          resolve_mispredict;
    logic [FW-1:0] free_list_restore;
    logic          restore_flag;
    logic [NC-1:0] squash_mask;
    logic [IB:0]   num_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string         tag;
        logic          rf;
        logic [FW-1:0] flr;
        logic [NC-1:0] sq;
        logic [IB:0]   nv;
        logic          full;
    } exp_t;

    exp_t sb_q[$];

    branch_ckpt_ctrl #(.NUM_CKPT(NC), .FL_WIDTH(FW)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_snapshot     (alloc_snapshot),
        .alloc_gnt          (alloc_gnt),
        .alloc_id           (alloc_id),
        .ckpt_full          (ckpt_full),
        .resolve_valid      (resolve_valid),
        .resolve_id         (resolve_id),
        .resolve_mispredict (resolve_mispredict),
        .free_list_restore  (free_list_restore),
        .restore_flag       (restore_flag),
        .squash_mask        (squash_mask),
        .num_valid          (num_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One directed step: drive inputs, check grant/id, queue and check the
    // registered outputs after the edge.
    task automatic cyc(input string tag,
                       input logic areq, input logic [FW-1:0] asnap,
                       input logic rv, input logic [IB-1:0] rid, input logic rm,
                       input logic e_gnt, input logic [IB-1:0] e_id,
                       input logic e_rf, input logic [FW-1:0] e_flr,
                       input logic [NC-1:0] e_sq, input logic [IB:0] e_nv,
                       input logic e_full);
        exp_t e;
        @(negedge clock);
        alloc_req          = areq;
        alloc_snapshot     = asnap;
        resolve_valid      = rv;
        resolve_id         = rid;
        resolve_mispredict = rm;
        #1;
        chk({tag, ".gnt"}, 32'(alloc_gnt), 32'(e_gnt));
        chk({tag, ".id"},  32'(alloc_id),  32'(e_id));
        e.tag = tag; e.rf = e_rf; e.flr = e_flr; e.sq = e_sq; e.nv = e_nv; e.full = e_full;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".restore_flag"}, 32'(restore_flag),      32'(e.rf));
        chk({e.tag, ".restore_snap"}, 32'(free_list_restore), 32'(e.flr));
        chk({e.tag, ".squash_mask"},  32'(squash_mask),       32'(e.sq));
        chk({e.tag, ".num_valid"},    32'(num_valid),         32'(e.nv));
        chk({e.tag, ".ckpt_full"},    32'(ckpt_full),         32'(e.full));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".restore_flag"}, 32'(restore_flag),      32'd0);
        chk({tag, ".restore_snap"}, 32'(free_list_restore), 32'd0);
        chk({tag, ".squash_mask"},  32'(squash_mask),       32'd0);
        chk({tag, ".num_valid"},    32'(num_valid),         32'd0);
        chk({tag, ".ckpt_full"},    32'(ckpt_full),         32'd0);
        chk({tag, ".alloc_id"},     32'(alloc_id),          32'd0);
    endtask

    initial begin
        reset = 1'b1; alloc_req = 1'b0; alloc_snapshot = 16'h0;
        resolve_valid = 1'b0; resolve_id = 2'd0; resolve_mispredict = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: fill all four slots, then a refused fifth request
        //         tag        areq asnap   rv   rid  rm   gnt  id   rf   flr      sq       nv    full
        cyc("t1.a0",   1'b1, 16'h0001, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);
        cyc("t1.a1",   1'b1, 16'h0002, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t1.a2",   1'b1, 16'h0004, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0);
        cyc("t1.a3",   1'b1, 16'h0008, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 4'b0000, 3'd4, 1'b1);
        cyc("t1.full", 1'b1, 16'h0010, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd4, 1'b1);

        // 2: mispredict id1 squashes 1..3 and restores snapshot 0x2
        cyc("t2.mp1",  1'b0, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0002, 4'b1110, 3'd1, 1'b0);
        cyc("t2.idle", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);

        // 3: in-order release waits for the head
        cyc("t3.a1",   1'b1, 16'h0020, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t3.ok1",  1'b0, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t3.ok0",  1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t3.rel0", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);
        cyc("t3.rel1", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0);

        // 4: wrap with head=3, tail=1; mispredict id0 keeps id3 live
        cyc("t4.a2",   1'b1, 16'h0100, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);
        cyc("t4.a3",   1'b1, 16'h0200, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t4.a0",   1'b1, 16'h0400, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0);
        cyc("t4.ok2",  1'b0, 16'h0000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0);
        cyc("t4.rel2", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t4.mp0",  1'b0, 16'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 16'h0400, 4'b0001, 3'd1, 1'b0);
        cyc("t4.idle", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);

        // 5: mispredict drops a same-cycle alloc; then mispredict + head release
        cyc("t5.a0ok3",1'b1, 16'h0800, 1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t5.a1rel",1'b1, 16'h1000, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t5.a2",   1'b1, 16'h2000, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0);
        cyc("t5.mp2",  1'b1, 16'hFFFF, 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 1'b1, 16'h2000, 4'b0100, 3'd2, 1'b0);
        cyc("t5.idle", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t5.ok0",  1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0);
        cyc("t5.mp1r", 1'b0, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b1, 16'h1000, 4'b0010, 3'd0, 1'b0);
        cyc("t5.idle2",1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0);

        // 6: resolve on an invalid id is ignored; reset during a restore pulse
        cyc("t6.a1",   1'b1, 16'h4000, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);
        cyc("t6.inv3", 1'b0, 16'h0000, 1'b1, 2'd3, 1'b1, 1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);
        cyc("t6.mp1",  1'b0, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b1, 16'h4000, 4'b0010, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1; alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        @(posedge clock);
        #1;
        check_zero("t6.rst");
        @(negedge clock);
        reset = 1'b0;
        cyc("t6.post", 1'b1, 16'h0001, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0);

        @(negedge clock);
        alloc_req = 1'b0; resolve_valid = 1'b0;
        chk("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
